mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the pipeline's instruction-fetch port and its load/store port. Each CPU cycle, it collects that cycle's fetch and data requests and serializes them onto the memory port, data first. It holds the pipeline with `cpu_stall` until every request for that cycle has completed. It sits between the CPU top level (`inst_*`, `data_*`, `cache_stall`) and the external memory / cache-miss path.

---
 rtl/arb_pkg.sv | 7 +
 rtl/arb_ibuf.sv | 34 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: FSM states and shared constants for mem_port_arbiter and its ARB_IBUF_EN fetch buffer
package arb_pkg;
  typedef enum logic [1:0] {IDLE, DATA, INST, HOLD} state_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int WORD_OFF = 2;
endpackage

// File: rtl/arb_ibuf.sv
// arb_ibuf: one-entry fetch buffer (tag/data/valid) with fill, lookup and store invalidation, used under ARB_IBUF_EN
module arb_ibuf import arb_pkg::*; #(
  parameter int TAG_W = DEF_ADDR_W - WORD_OFF,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              inval,
  input  logic [TAG_W-1:0]  inval_tag
);
  logic valid;
  logic [TAG_W-1:0] tag;
  logic [DATA_W-1:0] data;
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      tag <= '0;
      data <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag <= fill_tag;
      data <= fill_data;
    end else if (inval && inval_tag == tag) begin
      valid <= 1'b0;
    end
  assign hit = valid && lookup_tag == tag;
  assign hit_data = data;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes each CPU cycle's data then fetch access onto one memory port; ARB_IBUF_EN adds a fetch buffer
module mem_port_arbiter import arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_re,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_re,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  state_t state, state_n;
  logic data_done, inst_done, data_done_n, inst_done_n;
  logic req_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, irdata_n, drdata_n;
  logic data_pend, inst_pend, hit, ib_hit;
  logic [DATA_W-1:0] ib_data;
  assign data_pend = (data_re | data_we) & ~data_done;
  assign inst_pend = inst_re & ~inst_done;
  assign cpu_stall = ~rst & (data_pend | inst_pend);
  assign hit = inst_pend & ib_hit;
`ifdef ARB_IBUF_EN
  arb_ibuf #(.TAG_W(ADDR_W - WORD_OFF), .DATA_W(DATA_W)) u_ibuf (
    .clk(clk),
    .rst(rst),
    .fill(state == INST && mem_ready),
    .fill_tag(mem_addr[ADDR_W-1:WORD_OFF]),
    .fill_data(mem_rdata),
    .lookup_tag(inst_addr[ADDR_W-1:WORD_OFF]),
    .hit(ib_hit),
    .hit_data(ib_data),
    .inval(state == DATA && mem_ready && mem_we),
    .inval_tag(mem_addr[ADDR_W-1:WORD_OFF])
  );
`else
  assign ib_hit = 1'b0;
  assign ib_data = '0;
`endif
  always_comb begin
    state_n = state;
    data_done_n = data_done;
    inst_done_n = inst_done;
    req_n = mem_req;
    we_n = mem_we;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    irdata_n = inst_rdata;
    drdata_n = data_rdata;
    case (state)
      IDLE: begin
        if (hit) begin
          inst_done_n = 1'b1;
          irdata_n = ib_data;
        end
        if (data_pend) begin
          state_n = DATA;
          req_n = 1'b1;
          we_n = data_we;
          addr_n = data_addr;
          wdata_n = data_wdata;
        end else if (hit) begin
          state_n = HOLD;
        end else if (inst_pend) begin
          state_n = INST;
          req_n = 1'b1;
          we_n = 1'b0;
          addr_n = inst_addr;
        end
      end
      DATA: if (mem_ready) begin
        data_done_n = 1'b1;
        drdata_n = mem_we ? data_rdata : mem_rdata;
        state_n = inst_pend ? INST : HOLD;
        req_n = inst_pend;
        we_n = 1'b0;
        addr_n = inst_pend ? inst_addr : mem_addr;
      end
      INST: if (mem_ready) begin
        inst_done_n = 1'b1;
        irdata_n = mem_rdata;
        req_n = 1'b0;
        state_n = HOLD;
      end
      HOLD: begin
        data_done_n = 1'b0;
        inst_done_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      data_done <= 1'b0;
      inst_done <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      state <= state_n;
      data_done <= data_done_n;
      inst_done <= inst_done_n;
      mem_req <= req_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      inst_rdata <= irdata_n;
      data_rdata <= drdata_n;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized CPU-cycle checks of mem_port_arbiter against a memory-level reference model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic inst_re = 1'b0, data_re = 1'b0, data_we = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, mem_req, mem_we, mem_ready;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_re(inst_re), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_re(data_re), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
`ifdef ARB_IBUF_EN
  localparam bit IB_EN = 1'b1;
`else
  localparam bit IB_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          lat;
  } txn_t;
  txn_t txq[$];
  txn_t cur;
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] ref_img [logic [31:0]];
  int tests = 0, fails = 0;
  int fix_lat = -1;
  int cnt = 0;
  bit busy = 1'b0, resp_en = 1'b1, man_ready = 1'b0;
  logic [31:0] man_rdata = '0;
  int ncyc, nstall;
  bit ib_v = 1'b0;
  logic [29:0] ib_tag = '0;
  logic [31:0] ib_d = '0, exp_i = '0, exp_d = '0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] seed(input logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_img.exists(a) ? ref_img[a] : seed(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem_img[a] = d;
    ref_img[a] = d;
  endtask

  // external memory: answers each request L cycles after it appears and logs it
  initial begin : responder
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (!resp_en) begin
        busy = 1'b0;
        mem_ready = man_ready;
        mem_rdata = man_rdata;
      end else begin
        if (busy)
          chk("mem_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, cur.we, cur.addr, cur.wdata});
        else if (mem_req) begin
          cur.addr = mem_addr;
          cur.we = mem_we;
          cur.wdata = mem_wdata;
          cur.lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 3));
          cnt = cur.lat;
          busy = 1'b1;
          txq.push_back(cur);
        end
        if (busy) begin
          if (cnt == 0) begin
            busy = 1'b0;
            mem_ready = 1'b1;
            if (cur.we) mem_img[cur.addr] = cur.wdata;
            else mem_rdata = mem_img.exists(cur.addr) ? mem_img[cur.addr] : seed(cur.addr);
          end else cnt--;
        end
      end
    end
  end

  task automatic op(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                    input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk);
    #1;
    txq.delete();
    inst_re = ir; inst_addr = ia; data_re = dr; data_we = dw; data_addr = da; data_wdata = dwd;
    ncyc = 0;
    nstall = 0;
    do begin
      @(negedge clk);
      ncyc++;
      if (cpu_stall) nstall++;
    end while (cpu_stall && ncyc < 100);
    chk("stall_release", cpu_stall, 1'b0);
  endtask

  // one CPU cycle: expected results follow from data-before-fetch ordering over the memory image
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dwd);
    bit dn, hit;
    int exp_tx, lat_sum;
    dn = dr | dw;
    hit = IB_EN && ir && ib_v && ib_tag == ia[31:2];
    if (hit) exp_i = ib_d;
    if (dw) begin
      ref_img[da] = dwd;
      if (ib_v && ib_tag == da[31:2]) ib_v = 1'b0;
    end else if (dr) exp_d = rd_ref(da);
    if (ir && !hit) begin
      exp_i = rd_ref(ia);
      ib_v = 1'b1;
      ib_tag = ia[31:2];
      ib_d = exp_i;
    end
    exp_tx = int'(dn) + int'(ir && !hit);
    op(ir, ia, dr, dw, da, dwd);
    chk("txn_count", txq.size(), exp_tx);
    lat_sum = 0;
    foreach (txq[i]) lat_sum += txq[i].lat + 1;
    if (txq.size() == exp_tx && dn) begin
      chk("data_first_addr", txq[0].addr, da);
      chk("data_first_we", txq[0].we, dw);
      if (dw) chk("store_wdata", txq[0].wdata, dwd);
    end
    if (txq.size() == exp_tx && exp_tx > int'(dn)) begin
      chk("fetch_addr", txq[exp_tx-1].addr, ia);
      chk("fetch_we", txq[exp_tx-1].we, 1'b0);
    end
    chk("period", ncyc, (dn || ir) ? 2 + lat_sum : 1);
    chk("stall_cycles", nstall, ncyc - 1);
    chk("inst_rdata", inst_rdata, exp_i);
    chk("data_rdata", data_rdata, exp_d);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ir, dr, dw;
    int sel;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);

    preload(32'h100, 32'h2402_0005);
    fix_lat = 0;
    step(1, 32'h100, 0, 0, 0, 0);
    chk("fetch_only_period", ncyc, 3);
    chk("fetch_only_word", inst_rdata, 32'h2402_0005);

    preload(32'h40, 32'hDEAD_BEEF);
    fix_lat = 2;
    step(1, 32'h104, 1, 0, 32'h40, 0);
    chk("load_fetch_period", ncyc, 8);
    chk("load_word", data_rdata, 32'hDEAD_BEEF);

    step(0, 0, 1, 1, 32'h80, 32'h1234);
    chk("store_keeps_rdata", data_rdata, 32'hDEAD_BEEF);

    resp_en = 1'b0;
    @(posedge clk);
    #1;
    inst_re = 1'b1; inst_addr = 32'h300; data_re = 1'b0; data_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_req_up", mem_req, 1'b1);
    chk("rst_mid_addr", mem_addr, 32'h300);
    @(posedge clk);
    #1;
    rst = 1'b1;
    inst_re = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", cpu_stall, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_drop", mem_req, 1'b0);
    chk("rst_mid_addr_clr", mem_addr, 32'h0);
    chk("rst_mid_inst_clr", inst_rdata, 32'h0);
    chk("rst_mid_data_clr", data_rdata, 32'h0);
    man_ready = 1'b1;
    man_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_inst", inst_rdata, 32'h0);
    chk("late_ready_req", mem_req, 1'b0);
    chk("late_ready_stall", cpu_stall, 1'b0);
    resp_en = 1'b1;
    exp_i = '0;
    exp_d = '0;
    ib_v = 1'b0;

`ifdef ARB_IBUF_EN
    fix_lat = 1;
    step(1, 32'h200, 0, 0, 0, 0);
    step(1, 32'h200, 0, 0, 0, 0);
    chk("ibuf_hit_no_req", txq.size(), 0);
    chk("ibuf_hit_period", ncyc, 2);
    step(0, 0, 1, 1, 32'h200, 32'hCAFE_F00D);
    step(1, 32'h200, 0, 0, 0, 0);
    chk("ibuf_inval_refetch", txq.size(), 1);
    chk("ibuf_inval_word", inst_rdata, 32'hCAFE_F00D);
`endif

    fix_lat = -1;
    for (int n = 0; n < 150; n++) begin
      ir = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      dr = sel == 1 || sel == 3 || (sel == 2 && 1'($urandom_range(0, 1)));
      dw = sel == 2;
      step(ir, 32'h1000 + ($urandom_range(0, 7) << 2), dr, dw,
           32'h1000 + ($urandom_range(0, 7) << 2), $urandom);
    end
    op(0, 0, 0, 0, 0, 0);
    chk("idle_period", ncyc, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
